cache_controller: RTL and testbench

Direct-mapped, write-back, write-allocate cache controller sitting between the CPU data port and the latency memory model. It accepts one CPU load or store at a time, serves hits from an internal line array, and on a miss drives the memory request handshake (`mem_read`/`mem_write` held until the `read_allocate`/`write_back` completion pulse). It also maintains hit and miss statistics counters for lab evaluation.

---
 rtl/cache_controller.sv | 135 +++++++++++++
 tb/tb_cache_controller.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/cache_controller.sv
// cache_controller: direct-mapped, write-back, write-allocate cache, one CPU request at a time.
// Ports: clk/rst; CPU request (cpu_req_valid/rw/addr/data) and response (cpu_ready/cpu_data);
//        memory handshake (mem_read/mem_write/mem_address/mem_wdata/mem_rdata/write_back/read_allocate);
//        statistics (hit_count/miss_count).
module cache_controller #(
  parameter int LINES   = 64,
  parameter int INDEX_W = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req_valid,
  input  logic        cpu_req_rw,
  input  logic [31:0] cpu_req_addr,
  input  logic [31:0] cpu_req_data,
  output logic        cpu_ready,
  output logic [31:0] cpu_data,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        write_back,
  input  logic        read_allocate,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int TAG_W = 32 - INDEX_W - 2;

  typedef enum logic [1:0] {IDLE, COMPARE, WRITE_BACK, ALLOCATE} state_t;

  state_t               state;
  logic                 req_rw;
  logic [TAG_W-1:0]     req_tag;
  logic [INDEX_W-1:0]   req_index;
  logic [31:0]          req_data;

  logic [LINES-1:0]     valid_bits;
  logic [LINES-1:0]     dirty_bits;
  logic [TAG_W-1:0]     tag_mem  [LINES];
  logic [31:0]          data_mem [LINES];

  logic [TAG_W-1:0]     line_tag;
  logic [31:0]          line_data;
  logic                 hit;

  // Word addressing: the byte offset never reaches the cache.
  logic unused_addr_bits;
  assign unused_addr_bits = ^cpu_req_addr[1:0];

  assign line_tag  = tag_mem[req_index];
  assign line_data = data_mem[req_index];
  assign hit       = (state == COMPARE) && valid_bits[req_index] && (line_tag == req_tag);

  // Control state, request registers, line status bits and statistics.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      req_rw     <= 1'b0;
      req_tag    <= '0;
      req_index  <= '0;
      req_data   <= '0;
      valid_bits <= '0;
      dirty_bits <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req_valid) begin
            req_rw    <= cpu_req_rw;
            req_tag   <= cpu_req_addr[31:INDEX_W+2];
            req_index <= cpu_req_addr[INDEX_W+1:2];
            req_data  <= cpu_req_data;
            state     <= COMPARE;
          end
        end
        COMPARE: begin
          if (hit) begin
            hit_count <= hit_count + 32'd1;
            if (req_rw) dirty_bits[req_index] <= 1'b1;
            state <= IDLE;
          end else begin
            miss_count <= miss_count + 32'd1;
            // Only a valid dirty victim needs to be written out first.
            if (valid_bits[req_index] && dirty_bits[req_index]) state <= WRITE_BACK;
            else                                                 state <= ALLOCATE;
          end
        end
        WRITE_BACK: begin
          if (write_back) begin
            dirty_bits[req_index] <= 1'b0;
            state <= ALLOCATE;
          end
        end
        ALLOCATE: begin
          if (read_allocate) begin
            valid_bits[req_index] <= 1'b1;
            dirty_bits[req_index] <= 1'b0;
            state <= COMPARE;  // retry: now guaranteed to hit
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag/data arrays carry no reset; writes are gated by state, which reset forces to IDLE.
  always_ff @(posedge clk) begin
    if (hit && req_rw) begin
      data_mem[req_index] <= req_data;
    end
    if (state == ALLOCATE && read_allocate) begin
      data_mem[req_index] <= mem_rdata;
      tag_mem[req_index]  <= req_tag;
    end
  end

  // Outputs decode from state and request registers only.
  always_comb begin
    cpu_ready   = hit;
    cpu_data    = (hit && !req_rw) ? line_data : 32'd0;
    mem_read    = (state == ALLOCATE);
    mem_write   = (state == WRITE_BACK);
    mem_address = 32'd0;
    mem_wdata   = 32'd0;
    if (state == WRITE_BACK) begin
      mem_address = {line_tag, req_index, 2'b00};
      mem_wdata   = line_data;
    end else if (state == ALLOCATE) begin
      mem_address = {req_tag, req_index, 2'b00};
    end
  end

endmodule

// File: tb/tb_cache_controller.sv
// tb_cache_controller: drives directed and random CPU requests into cache_controller,
// plays the memory side with configurable latency and checks every response against
// a line-level cache model and a backing-store array.
module tb_cache_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req_valid;
  logic        cpu_req_rw;
  logic [31:0] cpu_req_addr;
  logic [31:0] cpu_req_data;
  logic        cpu_ready;
  logic [31:0] cpu_data;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        write_back;
  logic        read_allocate;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int checks   = 0;
  int failures = 0;

  // Reference model: one entry per line plus a sparse backing memory.
  bit          m_valid [64];
  bit          m_dirty [64];
  logic [23:0] m_tag   [64];
  logic [31:0] m_data  [64];
  logic [31:0] backing [logic [31:0]];
  int          exp_hit;
  int          exp_miss;

  always #5 clk = ~clk;

  cache_controller #(.LINES(64), .INDEX_W(6)) dut (
    .clk(clk), .rst(rst),
    .cpu_req_valid(cpu_req_valid), .cpu_req_rw(cpu_req_rw),
    .cpu_req_addr(cpu_req_addr), .cpu_req_data(cpu_req_data),
    .cpu_ready(cpu_ready), .cpu_data(cpu_data),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .write_back(write_back), .read_allocate(read_allocate),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (!backing.exists(a)) backing[a] = $urandom;
    return backing[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    exp_hit  = 0;
    exp_miss = 0;
  endtask

  // Model the completed hit (original or retried) on line idx.
  task automatic model_hit(input logic rw, input int idx, input logic [31:0] wdata);
    exp_hit++;
    if (rw) begin
      m_data[idx]  = wdata;
      m_dirty[idx] = 1'b1;
    end
  endtask

  // One full CPU transaction with memory latencies lat_wb / lat_rd (cycles mem_* is held, >= 1).
  task automatic do_req(input logic rw, input logic [31:0] addr, input logic [31:0] wdata,
                        input int lat_wb, input int lat_rd, input bit spur);
    int          idx;
    logic [23:0] tg;
    logic [31:0] word;
    logic [31:0] victim;
    idx  = int'(addr[7:2]);
    tg   = addr[31:8];
    word = {addr[31:2], 2'b00};

    @(negedge clk);
    write_back    = 1'b0;
    read_allocate = 1'b0;
    cpu_req_valid = 1'b1;
    cpu_req_rw    = rw;
    cpu_req_addr  = addr;
    cpu_req_data  = wdata;

    @(negedge clk);
    cpu_req_valid = 1'b0;
    cpu_req_addr  = $urandom;
    cpu_req_data  = $urandom;
    chk("cmp_mem_read", {31'd0, mem_read}, 32'd0);
    chk("cmp_mem_write", {31'd0, mem_write}, 32'd0);

    if (m_valid[idx] && m_tag[idx] == tg) begin
      chk("hit_ready", {31'd0, cpu_ready}, 32'd1);
      if (!rw) chk("hit_data", cpu_data, m_data[idx]);
      model_hit(rw, idx, wdata);
    end else begin
      chk("miss_ready", {31'd0, cpu_ready}, 32'd0);
      exp_miss++;
      if (m_valid[idx] && m_dirty[idx]) begin
        victim = {m_tag[idx], addr[7:2], 2'b00};
        for (int c = 1; c <= lat_wb; c++) begin
          @(negedge clk);
          write_back = 1'b0;
          chk("wb_mem_write", {31'd0, mem_write}, 32'd1);
          chk("wb_mem_read", {31'd0, mem_read}, 32'd0);
          chk("wb_addr", mem_address, victim);
          chk("wb_data", mem_wdata, m_data[idx]);
          if (c == lat_wb) write_back = 1'b1;
        end
        backing[victim] = m_data[idx];
        m_dirty[idx] = 1'b0;
      end
      for (int c = 1; c <= lat_rd; c++) begin
        @(negedge clk);
        write_back    = 1'b0;
        read_allocate = 1'b0;
        mem_rdata     = $urandom;
        chk("alloc_mem_read", {31'd0, mem_read}, 32'd1);
        chk("alloc_mem_write", {31'd0, mem_write}, 32'd0);
        chk("alloc_addr", mem_address, word);
        chk("alloc_ready", {31'd0, cpu_ready}, 32'd0);
        if (c == lat_rd) begin
          read_allocate = 1'b1;
          mem_rdata     = mem_word(word);
        end
      end
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
      m_tag[idx]   = tg;
      m_data[idx]  = mem_word(word);

      @(negedge clk);
      read_allocate = 1'b0;
      mem_rdata     = $urandom;
      chk("retry_mem_read", {31'd0, mem_read}, 32'd0);
      chk("retry_ready", {31'd0, cpu_ready}, 32'd1);
      if (!rw) chk("retry_data", cpu_data, m_data[idx]);
      model_hit(rw, idx, wdata);
    end

    @(negedge clk);
    chk("idle_ready", {31'd0, cpu_ready}, 32'd0);
    chk("hit_count", hit_count, exp_hit);
    chk("miss_count", miss_count, exp_miss);
    // Completion pulses outside the wait states must be ignored.
    if (spur) begin
      write_back    = 1'b1;
      read_allocate = 1'b1;
    end
  endtask

  initial begin
    rst           = 1'b1;
    cpu_req_valid = 1'b0;
    cpu_req_rw    = 1'b0;
    cpu_req_addr  = 32'd0;
    cpu_req_data  = 32'd0;
    mem_rdata     = 32'd0;
    write_back    = 1'b0;
    read_allocate = 1'b0;
    model_clear();

    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, cpu_ready}, 32'd0);
    chk("rst_mem_read", {31'd0, mem_read}, 32'd0);
    chk("rst_mem_write", {31'd0, mem_write}, 32'd0);
    chk("rst_cpu_data", cpu_data, 32'd0);
    chk("rst_mem_address", mem_address, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_hit_count", hit_count, 32'd0);
    chk("rst_miss_count", miss_count, 32'd0);
    rst = 1'b0;

    // Directed sequence.
    backing[32'h100] = 32'hDEAD_BEEF;
    do_req(1'b0, 32'h0000_0100, 32'h0, 1, 3, 1'b0);
    chk("first_load_hits", hit_count, 32'd1);
    chk("first_load_misses", miss_count, 32'd1);
    do_req(1'b0, 32'h0000_0100, 32'h0, 1, 1, 1'b0);
    do_req(1'b1, 32'h0000_0100, 32'h1234_5678, 1, 1, 1'b1);
    do_req(1'b0, 32'h0000_4100, 32'h0, 2, 2, 1'b0);
    chk("wb_stored", backing[32'h100], 32'h1234_5678);
    do_req(1'b0, 32'h0000_8100, 32'h0, 1, 7, 1'b1);
    do_req(1'b0, 32'h0000_4100, 32'h0, 1, 1, 1'b0);

    // Random traffic over a small tag/index pool so hits, clean and dirty misses all occur.
    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      do_req(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(1, 7),
             $urandom_range(1, 7), 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of an allocate.
    @(negedge clk);
    write_back    = 1'b0;
    read_allocate = 1'b0;
    cpu_req_valid = 1'b1;
    cpu_req_rw    = 1'b0;
    cpu_req_addr  = 32'h0000_0F04;
    @(negedge clk);
    cpu_req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_mem_read", {31'd0, mem_read | mem_write}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_drop_mem_read", {31'd0, mem_read}, 32'd0);
    chk("rst_drop_mem_write", {31'd0, mem_write}, 32'd0);
    chk("rst_drop_address", mem_address, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    chk("rst_clear_misses", miss_count, 32'd0);
    do_req(1'b0, 32'h0000_0100, 32'h0, 1, 2, 1'b0);
    chk("post_rst_miss", miss_count, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
